// File: rtl/interrupt_sequencer.sv
// External interrupt entry/exit sequencer for the 5-stage pipeline: picks a winner, flushes,
// redirects fetch to the vector, and on mret redirects back to the saved return PC.
module interrupt_sequencer #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned CAUSE_W     = 2,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0100,
    parameter int unsigned HOLDOFF     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               PCSrcE,
    input  logic               StallD,
    input  logic               mret_E,
    input  logic               ValidM,
    input  logic               ValidE,
    input  logic               ValidD,
    input  logic [31:0]        PCM,
    input  logic [31:0]        PCE,
    input  logic [31:0]        PCD,
    input  logic [31:0]        PCF,
    output logic               stopped_interrupt,
    output logic               interrupt_en,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_handler
);

    localparam int unsigned HoldW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned PadW  = 30 - CAUSE_W;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StVector,
        StHandler,
        StReturn
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    logic [31:0]        epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [HoldW-1:0]   holdoff_q, holdoff_d;

    logic [NUM_IRQ-1:0] pending;
    logic [CAUSE_W-1:0] winner;
    logic               take;

    assign pending = irq_req & mask_q;

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    assign take = (state_q == StIdle) && (|pending) && gie_q && (holdoff_q == '0) &&
                  !PCSrcE && !StallD;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_we ? mask_wdata : mask_q;
        gie_d     = gie_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        holdoff_d = (holdoff_q != '0) ? holdoff_q - HoldW'(1) : holdoff_q;

        stopped_interrupt = 1'b0;
        interrupt_en      = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        irq_ack           = '0;

        unique case (state_q)
            StIdle: begin
                // Winner is captured at the take edge so a request dropped during FLUSH
                // cannot change which line is acknowledged.
                if (take) begin
                    state_d = StFlush;
                    cause_d = winner;
                end
            end
            StFlush: begin
                stopped_interrupt = 1'b1;
                gie_d             = 1'b0;
                if (ValidM) begin
                    epc_d = PCM;
                end else if (ValidE) begin
                    epc_d = PCE;
                end else if (ValidD) begin
                    epc_d = PCD;
                end else begin
                    epc_d = PCF;
                end
                state_d = StVector;
            end
            StVector: begin
                interrupt_en   = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = VECTOR_BASE + {{PadW{1'b0}}, cause_q, 2'b00};
                irq_ack        = {{(NUM_IRQ - 1){1'b0}}, 1'b1} << cause_q;
                state_d        = StHandler;
            end
            StHandler: begin
                if (mret_E) begin
                    state_d = StReturn;
                end
            end
            StReturn: begin
                interrupt_en   = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = epc_q;
                gie_d          = 1'b1;
                holdoff_d      = HoldW'(HOLDOFF);
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mask_q    <= '0;
            gie_q     <= 1'b1;
            epc_q     <= '0;
            cause_q   <= '0;
            holdoff_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            holdoff_q <= holdoff_d;
        end
    end

    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_handler = (state_q != StIdle);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: scenario tasks with a queue of expected
// redirects pushed when an interrupt or mret is driven and popped when the redirect appears.
module tb_interrupt_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_req;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        PCSrcE, StallD, mret_E;
    logic        ValidM, ValidE, ValidD;
    logic [31:0] PCM, PCE, PCD, PCF;
    logic        stopped_interrupt, interrupt_en, redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  irq_ack;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_handler;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  ack;
        logic [1:0]  cause;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    interrupt_sequencer #(
        .NUM_IRQ    (4),
        .CAUSE_W    (2),
        .VECTOR_BASE(32'h0000_0100),
        .HOLDOFF    (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .irq_req          (irq_req),
        .mask_we          (mask_we),
        .mask_wdata       (mask_wdata),
        .PCSrcE           (PCSrcE),
        .StallD           (StallD),
        .mret_E           (mret_E),
        .ValidM           (ValidM),
        .ValidE           (ValidE),
        .ValidD           (ValidD),
        .PCM              (PCM),
        .PCE              (PCE),
        .PCD              (PCD),
        .PCF              (PCF),
        .stopped_interrupt(stopped_interrupt),
        .interrupt_en     (interrupt_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .irq_ack          (irq_ack),
        .epc              (epc),
        .cause            (cause),
        .in_handler       (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stopped_interrupt === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // From a VECTOR observation: one HANDLER cycle, mret, RETURN, then drain the holdoff.
    task automatic finish_handler();
        tick();
        mret_E = 1'b1;
        tick();
        mret_E = 1'b0;
        repeat (4) tick();
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++; if (stopped_interrupt !== 1'b0 || interrupt_en !== 1'b0 || redirect_valid !== 1'b0)
            begin n_err++; $display("FAIL reset_pulses: got %b%b%b want 000", stopped_interrupt,
            interrupt_en, redirect_valid); end
        n_vec++; if (irq_ack !== 4'b0) begin n_err++;
            $display("FAIL reset_ack: got %b want 0000", irq_ack); end
        n_vec++; if (epc !== 32'h0 || cause !== 2'd0) begin n_err++;
            $display("FAIL reset_epc_cause: got %h/%0d want 0/0", epc, cause); end
        n_vec++; if (in_handler !== 1'b0) begin n_err++;
            $display("FAIL reset_in_handler: got %b want 0", in_handler); end
        irq_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
                $display("FAIL reset_mask_zero: got %b want 0 (cycle %0d)", stopped_interrupt, i); end
        end
        irq_req = 4'b0;
        tick();
    endtask

    task automatic test_mask_vector();
        mask_we    = 1'b1;
        mask_wdata = 4'b0101;
        irq_req    = 4'b0100;
        tick();
        mask_we = 1'b0;
        n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
            $display("FAIL t1_old_mask: got %b want 0", stopped_interrupt); end
        sb.push_back('{pc: 32'h108, ack: 4'b0100, cause: 2'd2});
        tick();
        n_vec++; if (stopped_interrupt !== 1'b1 || in_handler !== 1'b1 || interrupt_en !== 1'b0)
            begin n_err++; $display("FAIL t1_flush: got stop=%b inh=%b ien=%b want 1 1 0",
            stopped_interrupt, in_handler, interrupt_en); end
        tick();
        e = sb.pop_front();
        n_vec++; if (redirect_valid !== 1'b1 || interrupt_en !== 1'b1 || redirect_pc !== e.pc)
            begin n_err++; $display("FAIL t1_vector: got v=%b ien=%b pc=%h want 1 1 %h",
            redirect_valid, interrupt_en, redirect_pc, e.pc); end
        n_vec++; if (irq_ack !== e.ack || cause !== e.cause) begin n_err++;
            $display("FAIL t1_ack_cause: got %b/%0d want %b/%0d", irq_ack, cause, e.ack, e.cause); end
        n_vec++; if (epc !== 32'h1000) begin n_err++;
            $display("FAIL t1_epc_pcf: got %h want 00001000", epc); end
        irq_req = 4'b0;
        tick();
        n_vec++; if (redirect_valid !== 1'b0 || in_handler !== 1'b1 || irq_ack !== 4'b0) begin
            n_err++; $display("FAIL t1_handler: got v=%b inh=%b ack=%b want 0 1 0000",
            redirect_valid, in_handler, irq_ack); end
        sb.push_back('{pc: 32'h1000, ack: 4'b0, cause: 2'd2});
        mret_E = 1'b1;
        tick();
        mret_E = 1'b0;
        e = sb.pop_front();
        n_vec++; if (redirect_valid !== 1'b1 || redirect_pc !== e.pc || irq_ack !== e.ack) begin
            n_err++; $display("FAIL t1_return: got v=%b pc=%h ack=%b want 1 %h %b",
            redirect_valid, redirect_pc, irq_ack, e.pc, e.ack); end
        tick();
        n_vec++; if (in_handler !== 1'b0) begin n_err++;
            $display("FAIL t1_back_idle: got %b want 0", in_handler); end
        repeat (3) tick();
    endtask

    task automatic test_priority();
        bit ok;
        bit saw;
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        ValidM  = 1'b1;
        ValidE  = 1'b1;
        irq_req = 4'b0101;
        sb.push_back('{pc: 32'h100, ack: 4'b0001, cause: 2'd0});
        wait_stop(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL t2_take: got no flush want flush"); end
        tick();
        ValidM = 1'b0;
        ValidE = 1'b0;
        e = sb.pop_front();
        n_vec++; if (redirect_pc !== e.pc || irq_ack !== e.ack || cause !== e.cause) begin
            n_err++; $display("FAIL t2_lowest_wins: got %h/%b/%0d want %h/%b/%0d",
            redirect_pc, irq_ack, cause, e.pc, e.ack, e.cause); end
        n_vec++; if (epc !== 32'h4000) begin n_err++;
            $display("FAIL t2_epc_pcm: got %h want 00004000", epc); end
        irq_req = 4'b0100;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (stopped_interrupt !== 1'b0 || in_handler !== 1'b1) saw = 1'b1;
        end
        n_vec++; if (saw) begin n_err++;
            $display("FAIL t2_no_nesting: got flush/exit in handler want none"); end
        mret_E = 1'b1;
        tick();
        mret_E = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (stopped_interrupt !== 1'b0) saw = 1'b1;
        end
        n_vec++; if (saw) begin n_err++;
            $display("FAIL t2_holdoff: got early flush want none"); end
        sb.push_back('{pc: 32'h108, ack: 4'b0100, cause: 2'd2});
        wait_stop(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL t2_line2: got no flush want flush"); end
        tick();
        e = sb.pop_front();
        n_vec++; if (redirect_pc !== e.pc || cause !== e.cause) begin n_err++;
            $display("FAIL t2_line2_vec: got %h/%0d want %h/%0d", redirect_pc, cause, e.pc, e.cause);
            end
        irq_req = 4'b0;
        finish_handler();
    endtask

    task automatic test_defer();
        irq_req = 4'b0010;
        PCSrcE  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
                $display("FAIL t3_pcsrc_defer: got %b want 0 (cycle %0d)", stopped_interrupt, i); end
        end
        PCSrcE = 1'b0;
        StallD = 1'b1;
        tick();
        n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
            $display("FAIL t3_stall_defer: got %b want 0", stopped_interrupt); end
        StallD = 1'b0;
        sb.push_back('{pc: 32'h104, ack: 4'b0010, cause: 2'd1});
        tick();
        n_vec++; if (stopped_interrupt !== 1'b1 || PCSrcE !== 1'b0) begin n_err++;
            $display("FAIL t3_flush_after: got %b want 1", stopped_interrupt); end
        tick();
        e = sb.pop_front();
        n_vec++; if (redirect_pc !== e.pc || irq_ack !== e.ack) begin n_err++;
            $display("FAIL t3_vector: got %h/%b want %h/%b", redirect_pc, irq_ack, e.pc, e.ack); end
        irq_req = 4'b0;
        finish_handler();
    endtask

    task automatic test_epc_return();
        bit ok;
        mret_E = 1'b1;
        tick();
        mret_E = 1'b0;
        n_vec++; if (redirect_valid !== 1'b0 || in_handler !== 1'b0) begin n_err++;
            $display("FAIL t4_mret_idle: got v=%b inh=%b want 0 0", redirect_valid, in_handler); end
        ValidM  = 1'b0;
        ValidE  = 1'b1;
        ValidD  = 1'b1;
        PCE     = 32'h40;
        irq_req = 4'b1000;
        sb.push_back('{pc: 32'h10C, ack: 4'b1000, cause: 2'd3});
        wait_stop(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL t4_take: got no flush want flush"); end
        tick();
        ValidE  = 1'b0;
        ValidD  = 1'b0;
        PCE     = 32'h3000;
        irq_req = 4'b0;
        e = sb.pop_front();
        n_vec++; if (redirect_pc !== e.pc || irq_ack !== e.ack || epc !== 32'h40) begin n_err++;
            $display("FAIL t4_vector: got pc=%h ack=%b epc=%h want %h %b 00000040",
            redirect_pc, irq_ack, epc, e.pc, e.ack); end
        // mret during VECTOR must not short-circuit the handler.
        mret_E = 1'b1;
        tick();
        n_vec++; if (redirect_valid !== 1'b0 || in_handler !== 1'b1) begin n_err++;
            $display("FAIL t4_mret_vector: got v=%b inh=%b want 0 1", redirect_valid, in_handler); end
        sb.push_back('{pc: 32'h40, ack: 4'b0, cause: 2'd3});
        tick();
        mret_E = 1'b0;
        e = sb.pop_front();
        n_vec++; if (redirect_valid !== 1'b1 || interrupt_en !== 1'b1 || redirect_pc !== e.pc) begin
            n_err++; $display("FAIL t4_return: got v=%b ien=%b pc=%h want 1 1 %h",
            redirect_valid, interrupt_en, redirect_pc, e.pc); end
        repeat (4) tick();
    endtask

    task automatic test_holdoff();
        bit ok;
        irq_req = 4'b0001;
        wait_stop(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL t5_take: got no flush want flush"); end
        tick();
        tick();
        mret_E = 1'b1;
        tick();
        mret_E = 1'b0;
        n_vec++; if (redirect_valid !== 1'b1) begin n_err++;
            $display("FAIL t5_return: got %b want 1", redirect_valid); end
        // Holdoff 3,2,1 block the take; the take at holdoff 0 shows as FLUSH one edge later.
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
                $display("FAIL t5_holdoff: got flush at cycle %0d want none", i); end
        end
        sb.push_back('{pc: 32'h100, ack: 4'b0001, cause: 2'd0});
        tick();
        n_vec++; if (stopped_interrupt !== 1'b1) begin n_err++;
            $display("FAIL t5_retake: got %b want 1", stopped_interrupt); end
        tick();
        irq_req = 4'b0;
        e = sb.pop_front();
        n_vec++; if (redirect_pc !== e.pc || irq_ack !== e.ack) begin n_err++;
            $display("FAIL t5_vector: got %h/%b want %h/%b", redirect_pc, irq_ack, e.pc, e.ack); end
        finish_handler();
    endtask

    task automatic test_reset_in_handler();
        bit ok;
        irq_req = 4'b0100;
        wait_stop(ok);
        tick();
        irq_req = 4'b0;
        tick();
        n_vec++; if (!ok || in_handler !== 1'b1 || epc === 32'h0) begin n_err++;
            $display("FAIL t6_setup: got ok=%b inh=%b epc=%h want 1 1 nonzero", ok, in_handler, epc);
            end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (in_handler !== 1'b0 || epc !== 32'h0 || cause !== 2'd0 || redirect_valid !== 1'b0)
            begin n_err++; $display("FAIL t6_reset: got inh=%b epc=%h cause=%0d v=%b want 0 0 0 0",
            in_handler, epc, cause, redirect_valid); end
        irq_req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
                $display("FAIL t6_mask_cleared: got %b want 0 (cycle %0d)", stopped_interrupt, i); end
        end
        mask_we    = 1'b1;
        mask_wdata = 4'b1000;
        tick();
        mask_we = 1'b0;
        n_vec++; if (stopped_interrupt !== 1'b0) begin n_err++;
            $display("FAIL t6_old_mask: got %b want 0", stopped_interrupt); end
        sb.push_back('{pc: 32'h10C, ack: 4'b1000, cause: 2'd3});
        tick();
        n_vec++; if (stopped_interrupt !== 1'b1) begin n_err++;
            $display("FAIL t6_gie_restored: got %b want 1", stopped_interrupt); end
        tick();
        irq_req = 4'b0;
        e = sb.pop_front();
        n_vec++; if (redirect_pc !== e.pc || cause !== e.cause) begin n_err++;
            $display("FAIL t6_vector: got %h/%0d want %h/%0d", redirect_pc, cause, e.pc, e.cause); end
        finish_handler();
    endtask

    initial begin
        reset      = 1'b1;
        irq_req    = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        PCSrcE     = 1'b0;
        StallD     = 1'b0;
        mret_E     = 1'b0;
        ValidM     = 1'b0;
        ValidE     = 1'b0;
        ValidD     = 1'b0;
        PCM        = 32'h4000;
        PCE        = 32'h3000;
        PCD        = 32'h2000;
        PCF        = 32'h1000;
        test_reset();
        test_mask_vector();
        test_priority();
        test_defer();
        test_epc_return();
        test_holdoff();
        test_reset_in_handler();
        n_vec++; if (sb.size() != 0) begin n_err++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
